stream_to_vga: RTL and testbench
================================

# stream_to_vga

Pixel-stream sink that turns a ready/valid raster stream (one beat per pixel, `first` on the top-left pixel, `lastx` on the last pixel of each line) into 640x480@60 VGA signals. It sits at the end of the render pipeline, the consuming end of the coordinate/pixel stream. It runs its own VGA timing counters and pulls exactly one beat per active pixel. It locks to the stream on `first` and drops lock with a status pulse on underflow or framing error.

## Interface
- `DATA_W`, 24: pixel width, packed {R,G,B}, 8 bits each.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in clocks.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.

Ports:
- `clk`  in  1  pixel clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_data`  in  DATA_W  pixel value.
- `s_first`  in  1  beat is pixel (0,0) of a frame.
- `s_lastx`  in  1  beat is the last pixel of a line.
- `s_valid`  in  1  beat present.
- `s_ready`  out  1  sink accepts the beat this cycle.
- `vga_r`/`vga_g`/`vga_b`  out  8 each  colour; 0 outside the active area or on a missing pixel.
- `vga_hs`, `vga_vs`  out  1  sync, active low.
- `vga_de`  out  1  active-area flag.
- `locked`  out  1  state is STREAM.
- `underflow`  out  1  one-cycle pulse: active pixel with no valid beat while locked.
- `desync`  out  1  one-cycle pulse: framing marker mismatch while locked.

## Operation
- Counters: `hcnt` runs 0..H_TOTAL-1 (799). `vcnt` runs 0..V_TOTAL-1 (524) and advances when `hcnt` wraps. They free-run in every state.
- active = `hcnt` < H_ACTIVE && `vcnt` < V_ACTIVE.
- hs is low for `hcnt` in [H_ACTIVE+H_FP, +H_SYNC), i.e. 656..751.
- vs is low for `vcnt` in 490..491.
- States:
  - SEEK (reset state):
    - `s_ready` = !`s_first`, combinational. Non-first beats are discarded.
    - On `s_valid && s_first`, go to WAIT. That beat is not consumed.
  - WAIT:
    - `s_ready`=0; the first beat is held upstream.
    - On the cycle `hcnt`=799 && `vcnt`=524, go to STREAM.
  - STREAM:
    - `s_ready` = active. A handshake consumes the beat for the current (`hcnt`,`vcnt`).
- Checks in STREAM on each active cycle:
  - `s_valid`=0: pulse `underflow`, output black, go to SEEK.
  - `s_valid`=1 and `s_first` ≠ (`hcnt`=0 && `vcnt`=0): pulse `desync`, go to SEEK.
  - `s_valid`=1 and `s_lastx` ≠ (`hcnt`=H_ACTIVE-1): pulse `desync`, go to SEEK.
  - A beat that fails a check is still consumed, but is displayed as black.
  - Underflow takes priority over desync. Only one pulse fires per event.
- In SEEK and WAIT the timing runs normally; rgb is 0 and `vga_de` still follows active.
- Inactive cycles never consume a beat, in any state except SEEK.

## Timing
- Reset (asynchronous, immediate):
  - `hcnt`=`vcnt`=0, state SEEK.
  - rgb=0, `vga_hs`=`vga_vs`=1, `vga_de`=0.
  - `locked`=`underflow`=`desync`=0.
- Release: counting starts on the first clock edge after `reset` falls.
- All `vga_*` outputs and `locked` are registered, one clock after the counter values they describe. A beat accepted at (h,v) appears on rgb on the next clock, aligned with that pixel's `vga_de`/`vga_hs`/`vga_vs`.
- `underflow`/`desync` are registered and assert on the clock after the offending cycle.
- `s_ready` is combinational from state, counters and `s_first` only. It never depends on `s_data` or `s_lastx`.
- Handshake: a beat transfers on a rising edge with `s_valid && s_ready`. Upstream must hold a beat until it transfers.
- Lock latency: from `first` presented in SEEK, the earliest `locked`=1 is the clock after the next (799,524).
- Reset mid-frame: state, counters and outputs clear immediately. The partially received frame is abandoned.
- Frame period: 800x525 = 420000 clocks. Line period: 800 clocks.

## Test plan
- Reset, then an ideal always-valid stream (640 beats per line, `lastx` on col 639, `first` on (0,0)):
  - `locked` rises within one frame and never drops over 3 frames.
  - Each frame consumes exactly 307200 beats.
  - rgb equals the input, delayed by one clock.
- Sync check with `s_valid`=0:
  - `vga_hs` low for exactly 96 clocks starting at `hcnt`=656.
  - `vga_vs` low for lines 490–491.
  - `vga_de` high for 640 clocks per line on lines 0..479.
- While locked, drop `s_valid` at pixel (100,20):
  - `underflow` pulses once; rgb is 0 for that pixel; `locked` falls.
  - Relock on the next frame's `first`.
- Inject `s_lastx`=1 at col 300 of line 5:
  - `desync` pulses once, `underflow` does not.
  - SEEK discards beats until `first`.
- Present 1000 non-first beats before the first `first` after reset:
  - All 1000 are accepted and discarded.
  - `s_ready` goes low on the `first` beat and stays low until (0,0).
- Assert `reset` mid-line at `hcnt`=400, `vcnt`=200:
  - Outputs take their reset values without waiting for a clock edge.
  - After release, the counters restart from (0,0).

Source files
------------

// File: rtl/stream_to_vga.sv
// stream_to_vga
// Pixel-stream sink that converts a ready/valid raster stream into VGA
// timing and colour. Free-running horizontal/vertical counters generate
// the raster; the sink locks to the stream on its `first` beat and pulls
// exactly one beat per active pixel while locked.
//
// Ports
//   clk, reset          pixel clock, asynchronous active-high reset
//   s_data              pixel value, packed {R,G,B}
//   s_first / s_lastx   framing markers: pixel (0,0) / last pixel of a line
//   s_valid / s_ready   stream handshake
//   vga_r/g/b           colour, black outside the active area or when missing
//   vga_hs / vga_vs     active-low syncs
//   vga_de              active-area flag
//   locked              sink is streaming
//   underflow / desync  one-cycle error pulses
//   dbg_state           current FSM state (0 SEEK, 1 WAIT, 2 STREAM)
//
// Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
// The source must hold a presented beat unchanged until it transfers.
// s_ready depends only on the FSM state, the counters and s_first.
module stream_to_vga #(
   parameter int DATA_W   = 24,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_first,
   input  logic              s_lastx,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_de,
   output logic              locked,
   output logic              underflow,
   output logic              desync,
   output logic [1:0]        dbg_state
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_EOL  = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      ST_SEEK   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     hcnt_q, hcnt_d;
   logic [VW-1:0]     vcnt_q, vcnt_d;
   logic [DATA_W-1:0] rgb_q, rgb_d;
   logic              hs_q, hs_d;
   logic              vs_q, vs_d;
   logic              de_q, de_d;
   logic              locked_q, locked_d;
   logic              underflow_q, underflow_d;
   logic              desync_q, desync_d;

   logic              active;
   logic              h_wrap;
   logic              frame_end;
   logic              beat_ok;

   // Raster counters and timing decode; these run in every state.
   always_comb begin
      h_wrap    = (hcnt_q == H_LAST);
      frame_end = h_wrap && (vcnt_q == V_LAST);
      active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hcnt_d    = h_wrap ? '0 : hcnt_q + 1'b1;
      vcnt_d    = vcnt_q;
      if (h_wrap) begin
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end
      hs_d = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs_d = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
      de_d = active;
      // Both markers must agree with the raster position for a beat to be shown.
      beat_ok = (s_first == ((hcnt_q == '0) && (vcnt_q == '0)))
             && (s_lastx == (hcnt_q == H_EOL));
   end

   // Lock FSM, handshake and pixel selection.
   always_comb begin
      state_d     = state_q;
      s_ready     = 1'b0;
      underflow_d = 1'b0;
      desync_d    = 1'b0;
      rgb_d       = '0;
      case (state_q)
         ST_SEEK: begin
            // Drain everything except the frame start, which is left
            // waiting upstream until the raster reaches (0,0).
            s_ready = !s_first;
            if (s_valid && s_first) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (frame_end) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            s_ready = active;
            if (active) begin
               if (!s_valid) begin
                  underflow_d = 1'b1;
                  state_d     = ST_SEEK;
               end else if (!beat_ok) begin
                  desync_d = 1'b1;
                  state_d  = ST_SEEK;
               end else begin
                  rgb_d = s_data;
               end
            end
         end
         default: state_d = ST_SEEK;
      endcase
      // Registered from the next state so that a lost lock shows on the
      // same cycle as the blanked pixel and the error pulse.
      locked_d = (state_d == ST_STREAM);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SEEK;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         rgb_q       <= '0;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         de_q        <= 1'b0;
         locked_q    <= 1'b0;
         underflow_q <= 1'b0;
         desync_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         rgb_q       <= rgb_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         de_q        <= de_d;
         locked_q    <= locked_d;
         underflow_q <= underflow_d;
         desync_q    <= desync_d;
      end
   end

   assign vga_r     = rgb_q[DATA_W-1 -: 8];
   assign vga_g     = rgb_q[DATA_W-9 -: 8];
   assign vga_b     = rgb_q[7:0];
   assign vga_hs    = hs_q;
   assign vga_vs    = vs_q;
   assign vga_de    = de_q;
   assign locked    = locked_q;
   assign underflow = underflow_q;
   assign desync    = desync_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_to_vga.sv
// Testbench for stream_to_vga, run with a shrunken raster (16x11 clocks per
// frame, 8x6 active) so that several frames fit in a short run.
module tb_stream_to_vga;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 6, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int NPIX = HA * VA;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] s_data = '0;
   logic        s_first = 1'b0, s_lastx = 1'b0, s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_de, locked, underflow, desync;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   stream_to_vga #(
      .DATA_W(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_first(s_first),
      .s_lastx(s_lastx), .s_valid(s_valid), .s_ready(s_ready),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs),
      .vga_vs(vga_vs), .vga_de(vga_de), .locked(locked),
      .underflow(underflow), .desync(desync), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Raster position is derived from elapsed clocks since reset release.
   int          m_t;
   int          m_mode;   // 0 seeking, 1 waiting for frame end, 2 streaming
   int          mh, mv;
   bit          mact;
   logic [23:0] e_rgb;
   logic        e_hs, e_vs, e_de, e_lock, e_uf, e_ds;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_t = 0; m_mode = 0;
         e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
         e_lock = 1'b0; e_uf = 1'b0; e_ds = 1'b0;
      end else begin
         mh = m_t % HT;
         mv = (m_t / HT) % VT;
         mact = (mh < HA) && (mv < VA);
         e_de = mact;
         e_hs = !(mh >= HA + HF && mh < HA + HF + HS);
         e_vs = !(mv >= VA + VF && mv < VA + VF + VS);
         e_uf = 1'b0; e_ds = 1'b0; e_rgb = '0;
         if (m_mode == 0) begin
            if (s_valid && s_first) m_mode = 1;
         end else if (m_mode == 1) begin
            if (m_t % FT == FT - 1) m_mode = 2;
         end else if (mact) begin
            if (!s_valid) begin
               e_uf = 1'b1; m_mode = 0;
            end else if ((s_first != (mh == 0 && mv == 0)) || (s_lastx != (mh == HA - 1))) begin
               e_ds = 1'b1; m_mode = 0;
            end else begin
               e_rgb = s_data;
            end
         end
         e_lock = (m_mode == 2);
         m_t = m_t + 1;
      end
   end

   // ---------------- per-cycle compare + monitors ----------------
   int   ch, cv;
   bit   exp_ready;
   int   uf_cnt, ds_cnt, lock_fall, hs_low, vs_low, de_cnt;
   int   edge_cnt, lock_edge, hs_edge;
   bit   lock_seen, hs_seen, lock_prev;
   logic [23:0] rgb_at_uf, rgb_at_ds;

   always @(posedge clk) if (!reset) edge_cnt++;

   always @(negedge clk) begin
      if (!reset) begin
         ch = m_t % HT;
         cv = (m_t / HT) % VT;
         exp_ready = (m_mode == 0) ? !s_first : (m_mode == 1) ? 1'b0 : (ch < HA && cv < VA);
         check("s_ready", s_ready, exp_ready);
         check("rgb", {vga_r, vga_g, vga_b}, e_rgb);
         check("hs", vga_hs, e_hs);
         check("vs", vga_vs, e_vs);
         check("de", vga_de, e_de);
         check("locked", locked, e_lock);
         check("underflow", underflow, e_uf);
         check("desync", desync, e_ds);
         if (underflow) begin uf_cnt++; rgb_at_uf = {vga_r, vga_g, vga_b}; end
         if (desync) begin ds_cnt++; rgb_at_ds = {vga_r, vga_g, vga_b}; end
         if (lock_prev && !locked) lock_fall++;
         lock_prev = locked;
         if (!vga_hs) hs_low++;
         if (!vga_vs) vs_low++;
         if (vga_de) de_cnt++;
         if (locked && !lock_seen) begin lock_seen = 1; lock_edge = edge_cnt; end
         if (!vga_hs && !hs_seen) begin hs_seen = 1; hs_edge = edge_cnt; end
      end
   end

   // ---------------- source driver ----------------
   int  sx, sy, fno, junk_left, junk_done, beats_since_first;
   bit  src_on, chk_beats, drop_arm, lx_arm, xfer;
   int  drop_x, drop_y, lx_x, lx_y;

   initial begin
      forever begin
         @(posedge clk);
         xfer = s_valid && s_ready && !reset;
         #1;
         if (reset) begin
            s_valid = 1'b0; s_first = 1'b0; s_lastx = 1'b0;
         end else begin
            if (xfer) begin
               if (junk_left > 0) begin
                  junk_left--; junk_done++;
               end else begin
                  if (s_first) begin
                     if (chk_beats && beats_since_first > 0)
                        check("frame_beats", beats_since_first, NPIX);
                     beats_since_first = 0;
                  end
                  beats_since_first++;
                  if (lx_arm && sx == lx_x && sy == lx_y) lx_arm = 0;
                  sx++;
                  if (sx == HA) begin
                     sx = 0; sy++;
                     if (sy == VA) begin sy = 0; fno++; end
                  end
               end
            end
            if (!src_on) begin
               s_valid = 1'b0; s_first = 1'b0; s_lastx = 1'b0;
            end else if (junk_left > 0) begin
               s_valid = 1'b1; s_first = 1'b0;
               s_lastx = 1'($urandom_range(0, 1));
               s_data = 24'($urandom);
            end else if (drop_arm && sx == drop_x && sy == drop_y) begin
               s_valid = 1'b0; s_first = 1'b0; s_lastx = 1'b0; drop_arm = 0;
            end else begin
               s_valid = 1'b1;
               s_first = (sx == 0 && sy == 0);
               s_lastx = (sx == HA - 1) || (lx_arm && sx == lx_x && sy == lx_y);
               s_data = {8'(sx) ^ 8'h5a, 8'(sy) ^ 8'h3c, 8'(fno) + 8'h11};
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_counts();
      uf_cnt = 0; ds_cnt = 0; lock_fall = 0; hs_low = 0; vs_low = 0; de_cnt = 0;
   endtask

   task automatic release_reset();
      edge_cnt = 0; lock_seen = 0; hs_seen = 0; lock_prev = 0;
      reset = 1'b0;
   endtask

   task automatic wait_lock(input int budget);
      int n;
      n = 0;
      while (!locked && n < budget) begin step(1); n++; end
      check("lock_reached", locked, 1'b1);
   endtask

   initial begin
      src_on = 0; chk_beats = 0; drop_arm = 0; lx_arm = 0;
      junk_left = 0; junk_done = 0; sx = 0; sy = 0; fno = 0;
      clear_counts();
      step(3);
      // Reset values while held in reset.
      check("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
      check("rst_hs", vga_hs, 1'b1);
      check("rst_vs", vga_vs, 1'b1);
      check("rst_de", vga_de, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_ready", s_ready, 1'b1);

      // Ideal always-valid stream.
      src_on = 1; chk_beats = 1; beats_since_first = 0;
      release_reset();
      wait_lock(2 * FT);
      check("lock_edge", lock_edge, 176);
      check("hs_first_fall_edge", hs_edge, 11);
      clear_counts();
      step(3 * FT);
      check("ideal_lock_fall", lock_fall, 0);
      check("ideal_underflow", uf_cnt, 0);
      check("ideal_desync", ds_cnt, 0);
      chk_beats = 0;

      // Syncs with no stream.
      src_on = 0;
      step(2 * FT);
      clear_counts();
      step(FT);
      check("hs_low_per_frame", hs_low, 33);
      check("vs_low_per_frame", vs_low, 32);
      check("de_per_frame", de_cnt, 48);
      check("idle_unlocked", locked, 1'b0);

      // Underflow at pixel (3,2), then relock.
      sx = 0; sy = 0; src_on = 1;
      wait_lock(3 * FT);
      clear_counts(); rgb_at_uf = 24'hffffff;
      drop_x = 3; drop_y = 2; drop_arm = 1;
      step(2 * FT);
      check("uf_pulses", uf_cnt, 1);
      check("uf_no_desync", ds_cnt, 0);
      check("uf_black", rgb_at_uf, 24'h0);
      check("uf_lock_fall", lock_fall, 1);
      check("uf_relocked", locked, 1'b1);

      // Spurious lastx at column 5 of line 1.
      clear_counts(); rgb_at_ds = 24'hffffff;
      lx_x = 5; lx_y = 1; lx_arm = 1;
      step(2 * FT);
      check("ds_pulses", ds_cnt, 1);
      check("ds_no_underflow", uf_cnt, 0);
      check("ds_black", rgb_at_ds, 24'h0);
      check("ds_lock_fall", lock_fall, 1);
      check("ds_relocked", locked, 1'b1);

      // 1000 non-first beats after reset, then the frame start.
      reset = 1'b1;
      sx = 0; sy = 0; junk_left = 1000; junk_done = 0;
      step(2);
      release_reset();
      begin
         int n;
         n = 0;
         while (junk_left > 0 && n < 1100) begin step(1); n++; end
      end
      check("junk_accepted", junk_done, 1000);
      check("ready_low_on_first", s_ready, 1'b0);
      check("junk_unlocked", locked, 1'b0);
      wait_lock(2 * FT);

      // Reset mid-line at (5,3).
      begin
         int n;
         n = 0;
         while (!((m_t % HT) == 5 && ((m_t / HT) % VT) == 3) && n < 2 * FT) begin step(1); n++; end
      end
      check("pre_reset_de", vga_de, 1'b1);
      reset = 1'b1;
      #1;
      check("async_rgb", {vga_r, vga_g, vga_b}, 24'h0);
      check("async_de", vga_de, 1'b0);
      check("async_locked", locked, 1'b0);
      check("async_hs", vga_hs, 1'b1);
      check("async_vs", vga_vs, 1'b1);
      sx = 0; sy = 0;
      step(2);
      release_reset();
      wait_lock(2 * FT);
      check("relock_edge", lock_edge, 176);
      check("restart_hs_edge", hs_edge, 11);
      step(FT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
